// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a single shared ALU.
// One operation in flight at a time. A request is accepted in IDLE, its
// operands are registered, the ALU result is registered during EXEC, and the
// result is offered to the owning requester in RESP until it is taken.

module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  // requester 0
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [2:0]       req_op_0,
  input  logic             req_alt_0,
  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  // requester 1
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic [2:0]       req_op_1,
  input  logic             req_alt_1,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  // shared response and status
  output logic [WIDTH-1:0] rsp_result,
  output logic             busy,
  output logic             owner,
  output logic [15:0]      ops_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q;       // requester granted most recently
  logic             owner_q;      // requester owning the current/last op
  logic             busy_q;
  logic [WIDTH-1:0] result_q;
  logic [15:0]      ops_done_q;

  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             alt_q;

  logic             grant_vld;
  logic             grant_idx;
  logic             accept;
  logic             rsp_take;
  logic [WIDTH-1:0] alu_res;

  // ALU sees only registered operands so its timing starts at a flop.
  alu #(.WIDTH(WIDTH)) u_alu (a_q, b_q, op_q, alt_q, alu_res);

  // Round-robin grant: on a tie the requester that did not win last time goes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    if (req_valid_0 && req_valid_1) begin
      grant_vld = 1'b1;
      grant_idx = ~last_q;
    end else if (req_valid_0) begin
      grant_vld = 1'b1;
      grant_idx = 1'b0;
    end else if (req_valid_1) begin
      grant_vld = 1'b1;
      grant_idx = 1'b1;
    end
  end

  assign accept      = (state_q == S_IDLE) && grant_vld;
  assign req_ready_0 = accept && (grant_idx == 1'b0);
  assign req_ready_1 = accept && (grant_idx == 1'b1);

  // Only the owner's rsp_ready completes a response; the other is ignored.
  assign rsp_take = (state_q == S_RESP) && (owner_q ? rsp_ready_1 : rsp_ready_0);

  // Next-state logic for the IDLE -> EXEC -> RESP -> IDLE sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_take) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, ownership, result and completion counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;            // requester 0 wins the first tie
      owner_q    <= 1'b0;
      busy_q     <= 1'b0;
      result_q   <= '0;
      ops_done_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples values from before the edge, independent of statement order.
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      if (accept) begin
        owner_q <= grant_idx;
        last_q  <= grant_idx;
      end
      if (state_q == S_EXEC) begin
        result_q <= alu_res;
      end
      if (rsp_take) begin
        ops_done_q <= ops_done_q + 16'd1;
      end
    end
  end

  // Operand capture on accept.
  // NOTE: operand registers carry no reset; they are only consumed after an
  // accept has loaded them, so a reset network here would buy nothing.
  always_ff @(posedge CLK) begin
    if (accept) begin
      if (grant_idx) begin
        a_q   <= req_a_1;
        b_q   <= req_b_1;
        op_q  <= req_op_1;
        alt_q <= req_alt_1;
      end else begin
        a_q   <= req_a_0;
        b_q   <= req_b_0;
        op_q  <= req_op_0;
        alt_q <= req_alt_0;
      end
    end
  end

  assign rsp_valid_0 = (state_q == S_RESP) && (owner_q == 1'b0);
  assign rsp_valid_1 = (state_q == S_RESP) && (owner_q == 1'b1);
  assign rsp_result  = result_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign ops_done    = ops_done_q;

endmodule

// alu: RV32-style integer ALU selected by funct3 plus an alternate-op bit.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  input  logic             alt_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;
  assign shamt = b_i[SHW-1:0];

  // Pure combinational operation select; SLT/SLTU produce a zero-extended bit.
  always_comb begin
    result_o = '0;
    unique case (op_i)
      3'b000:  result_o = alt_i ? (a_i - b_i) : (a_i + b_i);
      3'b001:  result_o = a_i << shamt;
      3'b010:  result_o[0] = ($signed(a_i) < $signed(b_i));
      3'b011:  result_o[0] = (a_i < b_i);
      3'b100:  result_o = a_i ^ b_i;
      3'b101:  result_o = alt_i ? $unsigned($signed(a_i) >>> shamt) : (a_i >> shamt);
      3'b110:  result_o = a_i | b_i;
      3'b111:  result_o = a_i & b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a directed vector table, hand-written
// contention / backpressure / reset / wrap sequences and a random phase, all
// compared every cycle against a transaction-level reference model.

module tb_alu_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        req_valid_0 = 0, req_valid_1 = 0;
  logic        req_ready_0, req_ready_1;
  logic [31:0] req_a_0 = 0, req_a_1 = 0, req_b_0 = 0, req_b_1 = 0;
  logic [2:0]  req_op_0 = 0, req_op_1 = 0;
  logic        req_alt_0 = 0, req_alt_1 = 0;
  logic        rsp_valid_0, rsp_valid_1;
  logic        rsp_ready_0 = 0, rsp_ready_1 = 0;
  logic [31:0] rsp_result;
  logic        busy, owner;
  logic [15:0] ops_done;

  alu_arbiter #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
    .req_a_0(req_a_0), .req_b_0(req_b_0), .req_op_0(req_op_0), .req_alt_0(req_alt_0),
    .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
    .req_a_1(req_a_1), .req_b_1(req_b_1), .req_op_1(req_op_1), .req_alt_1(req_alt_1),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
    .rsp_result(rsp_result), .busy(busy), .owner(owner), .ops_done(ops_done)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic alt);
    int sh;
    longint unsigned wide;
    sh = int'(b % 32);
    case (op)
      3'd0: return alt ? a - b : a + b;
      3'd1: begin wide = longint'(a) * (64'd1 << sh); return wide[31:0]; end
      3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (alt && a[31]) return ~((~a) / (32'd1 << sh));
        return a / (32'd1 << sh);
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  int          m_age;    // -1: no op in flight; 0: computing; >=1: result offered
  logic        m_last, m_owner;
  logic [31:0] m_res, m_pend;
  logic [15:0] m_cnt;
  int          ev_acc, ev_done;

  task automatic model_reset();
    m_age = -1; m_last = 1'b1; m_owner = 1'b0; m_res = '0; m_pend = '0; m_cnt = '0;
  endtask

  function automatic int exp_grant();
    if (req_valid_0 && req_valid_1) return m_last ? 0 : 1;
    if (req_valid_0) return 0;
    if (req_valid_1) return 1;
    return -1;
  endfunction

  // Predict the effect of the coming clock edge from the current inputs.
  task automatic model_advance();
    int g;
    ev_acc = -1; ev_done = -1;
    if (RST) begin
      model_reset();
    end else if (m_age < 0) begin
      g = exp_grant();
      if (g >= 0) begin
        m_owner = g[0]; m_last = g[0]; m_age = 0; ev_acc = g;
        m_pend = (g == 0) ? ref_alu(req_a_0, req_b_0, req_op_0, req_alt_0)
                          : ref_alu(req_a_1, req_b_1, req_op_1, req_alt_1);
      end
    end else if (m_age == 0) begin
      m_res = m_pend; m_age = 1;
    end else if (m_owner ? rsp_ready_1 : rsp_ready_0) begin
      m_cnt = m_cnt + 16'd1; ev_done = int'(m_owner); m_age = -1;
    end else begin
      m_age++;
    end
  endtask

  task automatic compare_all();
    int g;
    g = (m_age < 0) ? exp_grant() : -1;
    check("req_ready_0", 32'(req_ready_0), 32'(g == 0));
    check("req_ready_1", 32'(req_ready_1), 32'(g == 1));
    check("ready_exclusive", 32'(req_ready_0 & req_ready_1), 32'd0);
    check("rsp_valid_0", 32'(rsp_valid_0), 32'(m_age >= 1 && m_owner == 1'b0));
    check("rsp_valid_1", 32'(rsp_valid_1), 32'(m_age >= 1 && m_owner == 1'b1));
    if (m_age >= 1) check("rsp_result", rsp_result, m_res);
    check("busy", 32'(busy), 32'(m_age >= 0));
    check("owner", 32'(owner), 32'(m_owner));
    check("ops_done", 32'(ops_done), 32'(m_cnt));
  endtask

  // One clock: model predicts the edge, then outputs are compared on the negedge.
  task automatic step();
    model_advance();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic set_req(input int r, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic alt);
    if (r == 0) begin
      req_valid_0 = v; req_a_0 = a; req_b_0 = b; req_op_0 = op; req_alt_0 = alt;
    end else begin
      req_valid_1 = v; req_a_1 = a; req_b_1 = b; req_op_1 = op; req_alt_1 = alt;
    end
  endtask

  task automatic drop_valid(input int r);
    if (r == 0) req_valid_0 = 1'b0;
    else        req_valid_1 = 1'b0;
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom % 4)
      0: return $urandom;
      1: return $urandom % 8;
      2: return 32'hFFFF_FFF8 + ($urandom % 8);
      default: return 32'h8000_0000 ^ ($urandom % 3);
    endcase
  endfunction

  // Issue one op on requester r and return the result seen on its response.
  task automatic run_one(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic alt, output logic [31:0] res);
    int  guard;
    bit  done;
    set_req(r, 1'b1, a, b, op, alt);
    if (r == 0) rsp_ready_0 = 1'b1; else rsp_ready_1 = 1'b1;
    res = 'x; done = 0; guard = 0;
    while (!done && guard < 20) begin
      step();
      guard++;
      if (ev_acc == r) drop_valid(r);
      if ((r == 0) ? rsp_valid_0 : rsp_valid_1) res = rsp_result;
      if (ev_done == r) done = 1;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL run_one_timeout: requester %0d got no completed response, required one", r);
    end
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
  endtask

  typedef struct {
    int          r;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic        alt;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] res;
    int          grants[$];
    int          guard;
    logic        last_before;

    tbl[0] = '{0, 32'd2,          32'd1,          3'b000, 1'b0, 32'd3,          "add"};
    tbl[1] = '{0, 32'd2,          32'd1,          3'b000, 1'b1, 32'd1,          "sub"};
    tbl[2] = '{1, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 3'b111, 1'b0, 32'hAAAA_AAAA, "and"};
    tbl[3] = '{1, 32'hAAAA_0000, 32'h5555_0000, 3'b110, 1'b0, 32'hFFFF_0000, "or"};
    tbl[4] = '{1, 32'hAAAA_FF00, 32'h5555_FF00, 3'b100, 1'b0, 32'hFFFF_0000, "xor"};
    tbl[5] = '{1, 32'hFFFF_FFFF, 32'd12,        3'b001, 1'b0, 32'hFFFF_F000, "sll"};
    tbl[6] = '{1, 32'hFFFF_FFFF, 32'd12,        3'b101, 1'b0, 32'h000F_FFFF, "srl"};
    tbl[7] = '{1, 32'hFFFF_FFFF, 32'd12,        3'b101, 1'b1, 32'hFFFF_FFFF, "sra"};
    tbl[8] = '{1, 32'hFFFF_FFFF, 32'd1,         3'b010, 1'b0, 32'd1,          "slt"};
    tbl[9] = '{1, 32'hFFFF_FFFF, 32'd1,         3'b011, 1'b0, 32'd0,          "sltu"};

    // ---- reset ----
    model_reset();
    #2 RST = 1'b1;
    #1;
    check("reset_rsp_valid_0", 32'(rsp_valid_0), 32'd0);
    check("reset_rsp_valid_1", 32'(rsp_valid_1), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_owner", 32'(owner), 32'd0);
    check("reset_ops_done", 32'(ops_done), 32'd0);
    check("reset_rsp_result", rsp_result, 32'd0);
    step(); step();
    RST = 1'b0;
    step();

    // ---- directed vector table ----
    for (int i = 0; i < 10; i++) begin
      run_one(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].alt, res);
      check({"vec_", tbl[i].name}, res, tbl[i].exp);
      if (i == 1) check("ops_done_after_two", 32'(ops_done), 32'd2);
    end

    // ---- contention: both valid continuously, strict alternation ----
    last_before = m_last;
    set_req(0, 1'b1, rand_opnd(), rand_opnd(), 3'($urandom), 1'($urandom));
    set_req(1, 1'b1, rand_opnd(), rand_opnd(), 3'($urandom), 1'($urandom));
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    guard = 0;
    while (grants.size() < 8 && guard < 60) begin
      step();
      guard++;
      if (ev_acc >= 0) begin
        grants.push_back(ev_acc);
        set_req(ev_acc, 1'b1, rand_opnd(), rand_opnd(), 3'($urandom), 1'($urandom));
      end
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    check("contention_grant_count", 32'(grants.size()), 32'd8);
    for (int i = 0; i < grants.size(); i++)
      check("contention_order", 32'(grants[i]), 32'((i % 2 == 0) ? !last_before : last_before));
    for (int i = 0; i < 6 && m_age >= 0; i++) step();

    // ---- response backpressure with non-owner rsp_ready ----
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    set_req(0, 1'b1, 32'd7, 32'd5, 3'b000, 1'b0);
    guard = 0;
    while (m_age < 1 && guard < 10) begin
      step(); guard++;
      if (ev_acc == 0) begin
        drop_valid(0);
        set_req(1, 1'b1, 32'd9, 32'd4, 3'b000, 1'b1);
      end
    end
    check("bp_reached_resp", 32'(rsp_valid_0), 32'd1);
    rsp_ready_1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_result", rsp_result, 32'd12);
      check("bp_hold_valid", 32'(rsp_valid_0), 32'd1);
      check("bp_hold_busy", 32'(busy), 32'd1);
      check("bp_req1_waits", 32'(req_ready_1), 32'd0);
    end
    rsp_ready_1 = 1'b0; rsp_ready_0 = 1'b1;
    step();
    check("bp_release_done", 32'(ev_done), 32'd0);
    rsp_ready_0 = 1'b0;
    step();
    check("bp_req1_accepted_next", 32'(ev_acc), 32'd1);
    drop_valid(1);
    rsp_ready_1 = 1'b1;
    for (int i = 0; i < 6 && m_age >= 0; i++) step();
    rsp_ready_1 = 1'b0;

    // ---- reset during RESP ----
    set_req(0, 1'b1, 32'd100, 32'd1, 3'b000, 1'b0);
    guard = 0;
    while (m_age < 1 && guard < 10) begin
      step(); guard++;
      if (ev_acc == 0) drop_valid(0);
    end
    RST = 1'b1;
    #1;
    check("midrst_rsp_valid_0", 32'(rsp_valid_0), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ops_done", 32'(ops_done), 32'd0);
    check("midrst_owner", 32'(owner), 32'd0);
    check("midrst_rsp_result", rsp_result, 32'd0);
    step();
    set_req(0, 1'b1, 32'd3, 32'd4, 3'b000, 1'b0);
    set_req(1, 1'b1, 32'd5, 32'd6, 3'b000, 1'b0);
    RST = 1'b0;
    step();
    check("post_reset_first_grant", 32'(ev_acc), 32'd0);
    drop_valid(0);
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    for (int i = 0; i < 12 && (m_age >= 0 || req_valid_1); i++) begin
      step();
      if (ev_acc >= 0) drop_valid(ev_acc);
    end

    // ---- random traffic ----
    for (int c = 0; c < 400; c++) begin
      if (!req_valid_0 && ($urandom % 4 == 0))
        set_req(0, 1'b1, rand_opnd(), rand_opnd(), 3'($urandom), 1'($urandom));
      if (!req_valid_1 && ($urandom % 4 == 0))
        set_req(1, 1'b1, rand_opnd(), rand_opnd(), 3'($urandom), 1'($urandom));
      rsp_ready_0 = 1'($urandom);
      rsp_ready_1 = 1'($urandom);
      step();
      if (ev_acc >= 0) drop_valid(ev_acc);
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    for (int i = 0; i < 6 && m_age >= 0; i++) step();
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;

    // ---- counter wrap ----
    step();
    force dut.ops_done_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    step();
    release dut.ops_done_q;
    step();
    run_one(0, 32'd1, 32'd1, 3'b000, 1'b0, res);
    check("wrap_result", res, 32'd2);
    check("wrap_ops_done", 32'(ops_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
